// File: rtl/dm_store_buffer_if.sv
// Bundled store, load-lookup and data-memory signals of the store buffer.
// master = MEM stage / dm side driving requests, slave = the buffer itself.
interface dm_store_buffer_if #(
    parameter int unsigned PTR_W = 2
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [31:0]      st_pc;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_hit;
    logic [31:0]      ld_data;
    logic             ld_stall;
    logic             dm_busy;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic [31:0]      dm_pc;
    logic [PTR_W:0]   count;

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
        input  st_ready, ld_hit, ld_data, ld_stall, dm_we, dm_addr, dm_wd, dm_pc, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
        output st_ready, ld_hit, ld_data, ld_stall, dm_we, dm_addr, dm_wd, dm_pc, count
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write FIFO in front of the data memory with load lookup over buffered stores.
// Define DM_STB_FWD_EN to forward matching store data; otherwise matching loads stall.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dm_store_buffer_if.slave   bus
);
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] head_idx, tail_idx;
    logic             full, empty, push, pop;

    // Pointers carry an extra wrap bit so full and empty stay distinguishable.
    assign count    = tail_q - head_q;
    assign full     = (count == DepthCnt);
    assign empty    = (count == '0);
    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign push     = bus.st_valid && !full;
    assign pop      = !empty && !bus.dm_busy;

    assign bus.st_ready = !full;
    assign bus.count    = count;
    assign bus.dm_we    = pop;
    assign bus.dm_addr  = {mem_q[head_idx].addr, 2'b00};
    assign bus.dm_wd    = mem_q[head_idx].data;
    assign bus.dm_pc    = mem_q[head_idx].pc;

    always_comb begin
        head_d = head_q + {{PTR_W{1'b0}}, pop};
        tail_d = tail_q + {{PTR_W{1'b0}}, push};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry payload is never reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_idx] <= '{addr: bus.st_addr[31:2], data: bus.st_data, pc: bus.st_pc};
        end
    end

    logic             match;
    logic [31:0]      fwd_data;
    logic [PTR_W:0]   k_off;
    logic [PTR_W-1:0] k_idx;

    // Walk oldest to youngest so the last hit leaves the youngest data selected.
    always_comb begin
        match    = 1'b0;
        fwd_data = '0;
        k_off    = '0;
        k_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            k_off = (PTR_W + 1)'(k);
            k_idx = head_idx + k_off[PTR_W-1:0];
            if ((k_off < count) && (mem_q[k_idx].addr == bus.ld_addr[31:2])) begin
                match    = 1'b1;
                fwd_data = mem_q[k_idx].data;
            end
        end
    end

`ifdef DM_STB_FWD_EN
    assign bus.ld_hit   = bus.ld_valid && match;
    assign bus.ld_data  = (bus.ld_valid && match) ? fwd_data : '0;
    assign bus.ld_stall = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
`else
    assign bus.ld_hit   = 1'b0;
    assign bus.ld_data  = '0;
    assign bus.ld_stall = bus.ld_valid && match;

    logic unused_bits;
    assign unused_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0], fwd_data};
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed table-driven bench for dm_store_buffer plus full/wrap and reset-mid-drain sequences.
module tb_dm_store_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam logic [31:0] PcKey = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    dm_store_buffer_if #(.PTR_W(PTR_W)) bus ();

    dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic        busy;
        logic        ld_v;
        logic [31:0] ld_a;
        int          e_cnt;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_match;
        logic [31:0] e_fwd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic b, logic lv,
                                logic [31:0] la, int c, logic we, logic [31:0] ea,
                                logic [31:0] ed, logic m, logic [31:0] f);
        vec_t v;
        v = '{st_v: sv, st_a: sa, st_d: sd, busy: b, ld_v: lv, ld_a: la, e_cnt: c, e_we: we,
              e_addr: ea, e_wd: ed, e_match: m, e_fwd: f};
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, id, got, want);
        end
    endtask

    // Drive at the falling edge, compare 1 ns later, then let the rising edge act.
    task automatic apply(input vec_t v, input int id);
        logic        e_hit, e_stall;
        logic [31:0] e_ld;
        @(negedge clk);
        bus.st_valid = v.st_v;
        bus.st_addr  = v.st_a;
        bus.st_data  = v.st_d;
        bus.st_pc    = v.st_a ^ PcKey;
        bus.dm_busy  = v.busy;
        bus.ld_valid = v.ld_v;
        bus.ld_addr  = v.ld_a;
        #1;
`ifdef DM_STB_FWD_EN
        e_hit   = v.ld_v && v.e_match;
        e_stall = 1'b0;
        e_ld    = e_hit ? v.e_fwd : 32'h0;
`else
        e_hit   = 1'b0;
        e_stall = v.ld_v && v.e_match;
        e_ld    = 32'h0;
`endif
        chk("count", id, 32'(bus.count), 32'(v.e_cnt));
        chk("st_ready", id, 32'(bus.st_ready), 32'(v.e_cnt != DEPTH));
        chk("dm_we", id, 32'(bus.dm_we), 32'(v.e_we));
        if (v.e_we) begin
            chk("dm_addr", id, bus.dm_addr, v.e_addr);
            chk("dm_wd", id, bus.dm_wd, v.e_wd);
            chk("dm_pc", id, bus.dm_pc, v.e_addr ^ PcKey);
        end
        chk("ld_hit", id, 32'(bus.ld_hit), 32'(e_hit));
        chk("ld_stall", id, 32'(bus.ld_stall), 32'(e_stall));
        chk("ld_data", id, bus.ld_data, e_ld);
        @(posedge clk);
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_pc    = '0;
        bus.dm_busy  = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;

        //            stv st_a       st_d          bsy ldv ld_a   cnt we e_addr  e_wd  m  fwd
        // basic push then single-cycle drain
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h10,  32'hAAAA0001, 0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  1, 1, 32'h10,
                         32'hAAAA0001, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        // fill while busy, 5th store dropped, then in-order drain
        tbl.push_back(mk(1, 32'h100, 32'h1,        1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h104, 32'h2,        1, 0, 32'h0,  1, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h108, 32'h3,        1, 0, 32'h0,  2, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h10C, 32'h4,        1, 0, 32'h0,  3, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h200, 32'h5,        1, 0, 32'h0,  4, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  4, 1, 32'h100, 32'h1, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  3, 1, 32'h104, 32'h2, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  2, 1, 32'h108, 32'h3, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  1, 1, 32'h10C, 32'h4, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        // two stores to one word: youngest forwarded, or stall until both drained
        tbl.push_back(mk(1, 32'h20,  32'h1,        1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h20,  32'h2,        1, 0, 32'h0,  1, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        1, 1, 32'h22, 2, 0, 32'h0,   32'h0, 1, 32'h2));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 1, 32'h22, 2, 1, 32'h20,  32'h1, 1, 32'h2));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 1, 32'h22, 1, 1, 32'h20,  32'h2, 1, 32'h2));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 1, 32'h22, 0, 0, 32'h0,   32'h0, 0, 32'h0));
        // neighbouring word does not match; same word with odd byte offset does
        tbl.push_back(mk(1, 32'h44,  32'h55,       1, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        1, 1, 32'h40, 1, 0, 32'h0,   32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        1, 1, 32'h47, 1, 0, 32'h0,   32'h0, 1, 32'h55));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  1, 1, 32'h44,  32'h55, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0, 0, 32'h0));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 0, 32'(bus.count), 32'h0);
        chk("rst_we", 0, 32'(bus.dm_we), 32'h0);
        chk("rst_ready", 0, 32'(bus.st_ready), 32'h1);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

        // full buffer with a held store: refused while full, then push+pop with wrap
        for (int i = 0; i < 4; i++) begin
            apply(mk(1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 1, 0, 32'h0, i, 0, 32'h0,
                     32'h0, 0, 32'h0), 100 + i);
        end
        apply(mk(1, 32'h310, 32'h34, 0, 0, 32'h0, 4, 1, 32'h300, 32'h30, 0, 32'h0), 104);
        apply(mk(1, 32'h310, 32'h34, 0, 0, 32'h0, 3, 1, 32'h304, 32'h31, 0, 32'h0), 105);
        apply(mk(0, 32'h0,   32'h0,  0, 0, 32'h0, 3, 1, 32'h308, 32'h32, 0, 32'h0), 106);
        apply(mk(0, 32'h0,   32'h0,  0, 0, 32'h0, 2, 1, 32'h30C, 32'h33, 0, 32'h0), 107);
        apply(mk(1, 32'h314, 32'h35, 0, 0, 32'h0, 1, 1, 32'h310, 32'h34, 0, 32'h0), 108);
        apply(mk(0, 32'h0,   32'h0,  0, 0, 32'h0, 1, 1, 32'h314, 32'h35, 0, 32'h0), 109);
        apply(mk(0, 32'h0,   32'h0,  0, 0, 32'h0, 0, 0, 32'h0,   32'h0,  0, 32'h0), 110);

        // reset mid-drain: write strobe must drop without a clock edge
        for (int i = 0; i < 3; i++) begin
            apply(mk(1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1, 0, 32'h0, i, 0, 32'h0,
                     32'h0, 0, 32'h0), 200 + i);
        end
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.dm_busy  = 1'b0;
        #1;
        chk("pre_rst_count", 203, 32'(bus.count), 32'h3);
        chk("pre_rst_we", 203, 32'(bus.dm_we), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_we", 204, 32'(bus.dm_we), 32'h0);
        chk("async_rst_count", 204, 32'(bus.count), 32'h0);
        chk("async_rst_ready", 204, 32'(bus.st_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0), 210 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
